ram_sx_arb: RTL and testbench
=============================

# ram_sx_arb

Multi-channel single-port RAM with a built-in round-robin arbiter: up to `CChCnt` requesters share one synchronous single-port array of `2^CAddrLen` words × `CDataLen` bits. Each cycle it grants at most one access. Read data returns one cycle after the grant, with a per-channel valid strobe, and is held stable between reads. It sits between the core's local-memory clients (fetch, load/store, DMA) and the on-chip block RAM. It supersedes the single-client RAM wrapper.

## Interface
Parameters:
- `CAddrLen`, 13, word address width.
- `CDataLen`, 128, word width; must be a multiple of 8.
- `CChCnt`, 4, number of requesting channels, 1..8.

Ports:
- `AClkH`  in  1  clock, rising edge.
- `AResetH`  in  1  reset, synchronous, active-high.
- `AClkHEn`  in  1  clock enable; all state advances only when high.
- `AReqRd`  in  CChCnt  per-channel read request, held until acked.
- `AReqWr`  in  CChCnt  per-channel write request, held until acked.
- `AAddr`  in  CChCnt*CAddrLen  per-channel address; channel k is at bits [k*CAddrLen +: CAddrLen].
- `AMosi`  in  CChCnt*CDataLen  per-channel write data.
- `AByteEn`  in  CChCnt*CDataLen/8  per-channel byte enables. Present only with the byte-enable macro.
- `AAck`  out  CChCnt  one-hot grant pulse, combinational, in the cycle the access is issued.
- `AMisoVld`  out  CChCnt  one-hot read-data-valid pulse, one cycle after the read grant.
- `AMiso`  out  CDataLen  read data; holds the last read word.

## Operation
- Request vector: `Req[k] = AReqRd[k] | AReqWr[k]`.
- Grant: the first set `Req` bit at or after the round-robin pointer `Ptr`, searching upward and wrapping modulo CChCnt.
- Issue: on a grant with `AClkHEn`=1:
  - `AAck[k]`=1.
  - The RAM is accessed with `AAddr[k]`.
  - `Ptr` <= k+1, wrapping to 0 when k+1 equals CChCnt.
- No request: `Ptr` is unchanged and the RAM address register holds its previous value, so there is no spurious access.
- Write (`AReqWr[k]`=1): the word at `AAddr[k]` is written with `AMosi[k]`. `AMisoVld` does not pulse.
- Both `AReqRd[k]` and `AReqWr[k]` asserted: treated as a write only. Ack pulses once and `AMisoVld` stays low.
- Read: in the cycle after the grant, `AMisoVld[k]`=1 and `AMiso` carries the word.
  - `AMiso` holds that word until the next read completes.
  - Back-to-back reads from different channels return in grant order, one per cycle.
- Read after write to the same address in the next cycle returns the new data.
- A requester must hold its request and payload stable until it sees `AAck`. It drops the request in the cycle after `AAck` or issues a new one.
- `AClkHEn`=0:
  - `AAck`=0 and `AMisoVld`=0.
  - `Ptr`, the pending-valid register and `AMiso` are frozen.
  - A valid pending from the last enabled grant appears on the next enabled cycle.

## Timing
- Reset (`AResetH`=1 at a clock edge): `Ptr`=0, pending valid=0, `AMiso`=0, `AMisoVld`=0. RAM contents are not cleared.
- `AAck` is combinational from `AReqRd`, `AReqWr`, `AClkHEn` and `Ptr`; it is forced to 0 while `AResetH` is high.
- Reset asserted in the cycle after a read grant: the pending valid is discarded and `AMisoVld` stays 0.
- Read latency is exactly 1 enabled cycle from `AAck` to `AMisoVld`. Throughput is 1 access per enabled cycle.
- Worst-case wait for a continuously requesting channel: CChCnt-1 grants.

## Configuration
- `RAM_SX_ARB_BYTE_EN` defined:
  - The `AByteEn` port exists.
  - On a write, only bytes whose enable bit is set are written; the other bytes keep their old value.
  - A write with all-zero `AByteEn` is still acked but does not change the RAM.
- `RAM_SX_ARB_BYTE_EN` not defined:
  - The `AByteEn` port is absent.
  - Every write updates the full word.

## Structure
- Package `ram_sx_pkg`:
  - Constant `CByteLen`=8.
  - Function `ChIdxLen(CChCnt)` returning the bit width needed to index a channel.
  - Typedef for the channel index.
- Sub-module `ram_sx_rr_arb`:
  - Parameter `CChCnt`.
  - Inputs: request vector, clock enable, reset.
  - Outputs: one-hot grant, encoded index, grant-valid.
  - Owns `Ptr`.
- The RAM array is inferred in the top level as a single-port array with registered address and byte-enabled write.

## Test plan
- Reset, then single read: write 0x11..11 to address 5 via channel 0, then read address 5 via channel 2 → `AAck[2]` in cycle t, `AMisoVld[2]`=1 and `AMiso`=0x11..11 at t+1, and `AMiso` holds that value afterwards.
- All four channels read addresses 0..3 simultaneously, continuously, from `Ptr`=0 → grants in order ch0, ch1, ch2, ch3, ch0, and so on, one per cycle; the data for each grant appears on the following cycle.
- Channel 1 asserts read and write together at address 7 with data 0xAB → the word is written, `AAck[1]` pulses once, and `AMisoVld` stays 0; a later read of address 7 returns 0xAB.
- `AClkHEn` low for 3 cycles right after a read grant → `AMisoVld` stays 0 during the gap and pulses with the correct data on the first enabled cycle.
- With `RAM_SX_ARB_BYTE_EN`: word 0xFFFF…FF, then a write of 0x00 with `AByteEn`=0x0001 → a read returns 0xFFFF…FF00.
- `AResetH` asserted in the cycle after a read grant → no `AMisoVld`, `AMiso`=0, and the next grant goes to the lowest-numbered requester (`Ptr`=0).

Source files
------------

// File: rtl/ram_sx_pkg.sv
// Shared constants and helpers for the multi-channel single-port RAM with round-robin arbiter.
package ram_sx_pkg;

    localparam int CByteLen  = 8;
    localparam int CChIdxMax = 3;

    // Wide enough for the largest supported channel count (8).
    typedef logic [CChIdxMax-1:0] ch_idx_t;

    function automatic int ChIdxLen(input int ch_cnt);
        return (ch_cnt <= 1) ? 1 : $clog2(ch_cnt);
    endfunction

endpackage

// File: rtl/ram_sx_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping; ptr moves past each grant.
module ram_sx_rr_arb
    import ram_sx_pkg::*;
#(
    parameter int CChCnt = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CChCnt-1:0] req,
    output logic [CChCnt-1:0] gnt,
    output ch_idx_t           idx,
    output logic              gnt_vld
);

    localparam int CPtrLen = ChIdxLen(CChCnt);

    logic [CPtrLen-1:0] ptr;

    // Scan offsets from ptr upward; the first requesting channel found wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        gnt_vld = 1'b0;
        if (!rst && en) begin
            for (int o = 0; o < CChCnt; o++) begin
                for (int k = 0; k < CChCnt; k++) begin
                    if (!gnt_vld && req[k] && (k == ((int'(ptr) + o) % CChCnt))) begin
                        gnt_vld = 1'b1;
                        gnt[k]  = 1'b1;
                        idx     = ch_idx_t'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= ((int'(idx) + 1) >= CChCnt) ? '0 : CPtrLen'(int'(idx) + 1);
        end
    end

endmodule

// File: rtl/ram_sx_arb.sv
// Multi-channel single-port RAM with built-in round-robin arbiter, one access per enabled cycle.
// Optional per-byte write enables via the RAM_SX_ARB_BYTE_EN macro (AByteEn port).
// Handshake: a channel holds AReqRd/AReqWr, AAddr, AMosi stable until AAck pulses; AAck is the
// one-hot issue strobe, and for reads AMisoVld pulses on the next enabled cycle with AMiso valid.
module ram_sx_arb
    import ram_sx_pkg::*;
#(
    parameter int CAddrLen = 13,
    parameter int CDataLen = 128,
    parameter int CChCnt   = 4
)
(
    input  logic                         AClkH,
    input  logic                         AResetH,
    input  logic                         AClkHEn,
    input  logic [CChCnt-1:0]            AReqRd,
    input  logic [CChCnt-1:0]            AReqWr,
    input  logic [CChCnt*CAddrLen-1:0]   AAddr,
    input  logic [CChCnt*CDataLen-1:0]   AMosi,
`ifdef RAM_SX_ARB_BYTE_EN
    input  logic [CChCnt*CDataLen/8-1:0] AByteEn,
`endif
    output logic [CChCnt-1:0]            AAck,
    output logic [CChCnt-1:0]            AMisoVld,
    output logic [CDataLen-1:0]          AMiso
);

    localparam int CBeLen = CDataLen / CByteLen;

    logic [CChCnt-1:0]   req;
    logic [CChCnt-1:0]   gnt;
    ch_idx_t             idx;
    logic                gnt_vld;
    logic [CAddrLen-1:0] addr;
    logic [CDataLen-1:0] wdata;
    logic [CBeLen-1:0]   be;
    logic                wr_sel;
    logic                wr_gnt;
    logic                rd_gnt;
    logic [CChCnt-1:0]   pend;
    logic [CDataLen-1:0] miso_q;
    logic [CDataLen-1:0] mem [0:(1<<CAddrLen)-1];

    assign req = AReqRd | AReqWr;

    ram_sx_rr_arb #(.CChCnt(CChCnt)) u_arb (
        .clk     (AClkH),
        .rst     (AResetH),
        .en      (AClkHEn),
        .req     (req),
        .gnt     (gnt),
        .idx     (idx),
        .gnt_vld (gnt_vld)
    );

    assign AAck = gnt;

    // Route the granted channel's payload to the array port.
    always_comb begin
        addr   = '0;
        wdata  = '0;
        be     = '0;
        wr_sel = 1'b0;
        for (int k = 0; k < CChCnt; k++) begin
            if (idx == ch_idx_t'(k)) begin
                addr   = AAddr[k*CAddrLen +: CAddrLen];
                wdata  = AMosi[k*CDataLen +: CDataLen];
                wr_sel = AReqWr[k];
`ifdef RAM_SX_ARB_BYTE_EN
                be     = AByteEn[k*CBeLen +: CBeLen];
`else
                be     = '1;
`endif
            end
        end
    end

    // Write wins when a channel asserts both read and write.
    assign wr_gnt = gnt_vld & wr_sel;
    assign rd_gnt = gnt_vld & ~wr_sel;

    always_ff @(posedge AClkH) begin
        if (wr_gnt) begin
            for (int b = 0; b < CBeLen; b++) begin
                if (be[b]) begin
                    mem[addr][b*CByteLen +: CByteLen] <= wdata[b*CByteLen +: CByteLen];
                end
            end
        end
    end

    // pend remembers which channel's read is in flight until the next enabled cycle shows it.
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            pend   <= '0;
            miso_q <= '0;
        end else if (AClkHEn) begin
            pend <= rd_gnt ? gnt : '0;
            if (rd_gnt) begin
                miso_q <= mem[addr];
            end
        end
    end

    assign AMisoVld = (AClkHEn && !AResetH) ? pend : '0;
    assign AMiso    = miso_q;

endmodule

// File: tb/tb_ram_sx_arb.sv
// Directed bench for ram_sx_arb: round-robin order, read latency, write priority, enable gaps, reset.
module tb_ram_sx_arb;

    localparam int AW = 13;
    localparam int DW = 128;
    localparam int CH = 4;
    localparam int BW = DW / 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic [CH-1:0]     rd;
    logic [CH-1:0]     wr;
    logic [CH*AW-1:0]  addr;
    logic [CH*DW-1:0]  mosi;
`ifdef RAM_SX_ARB_BYTE_EN
    logic [CH*BW-1:0]  be;
`endif
    logic [CH-1:0]     ack;
    logic [CH-1:0]     miso_vld;
    logic [DW-1:0]     miso;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];
    int            ch_q[$];
    logic [DW-1:0] exp_miso;
    logic [DW-1:0] model_mem [int];

    ram_sx_arb #(.CAddrLen(AW), .CDataLen(DW), .CChCnt(CH)) dut (
        .AClkH    (clk),
        .AResetH  (rst),
        .AClkHEn  (en),
        .AReqRd   (rd),
        .AReqWr   (wr),
        .AAddr    (addr),
        .AMosi    (mosi),
`ifdef RAM_SX_ARB_BYTE_EN
        .AByteEn  (be),
`endif
        .AAck     (ack),
        .AMisoVld (miso_vld),
        .AMiso    (miso)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input int a, input logic [DW-1:0] d);
        addr[k*AW +: AW] = AW'(a);
        mosi[k*DW +: DW] = d;
    endtask

    // Sample mid-cycle, score against expected grant and scoreboard, then advance one clock.
    task automatic step(input string tag, input logic [CH-1:0] exp_ack);
        logic [CH-1:0] exp_vld;
        logic [DW-1:0] d;
        int            a;
        #2;
        chk($sformatf("%s_ack", tag), DW'(ack), DW'(exp_ack));
        exp_vld = '0;
        if (!rst && en && exp_q.size() > 0) begin
            exp_vld = CH'(1 << ch_q[0]);
            chk($sformatf("%s_vld", tag), DW'(miso_vld), DW'(exp_vld));
            chk($sformatf("%s_data", tag), miso, exp_q[0]);
            exp_miso = exp_q.pop_front();
            void'(ch_q.pop_front());
        end else begin
            chk($sformatf("%s_vld", tag), DW'(miso_vld), DW'(exp_vld));
            if (exp_q.size() == 0) chk($sformatf("%s_hold", tag), miso, exp_miso);
        end
        if (rst) begin
            exp_q.delete();
            ch_q.delete();
            exp_miso = '0;
        end
        for (int k = 0; k < CH; k++) begin
            if (exp_ack[k]) begin
                a = int'(addr[k*AW +: AW]);
                if (wr[k]) begin
                    d = model_mem.exists(a) ? model_mem[a] : '0;
`ifdef RAM_SX_ARB_BYTE_EN
                    for (int b = 0; b < BW; b++)
                        if (be[k*BW + b]) d[b*8 +: 8] = mosi[k*DW + b*8 +: 8];
`else
                    d = mosi[k*DW +: DW];
`endif
                    model_mem[a] = d;
                end else if (rd[k]) begin
                    exp_q.push_back(model_mem[a]);
                    ch_q.push_back(k);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rd = '0; wr = '0; addr = '0; mosi = '0;
        exp_miso = '0;
`ifdef RAM_SX_ARB_BYTE_EN
        be = '1;
`endif
        @(posedge clk);
        #1;
        rd = '1;
        step("rst_a", 4'b0000);
        step("rst_b", 4'b0000);
        rst = 1'b0; rd = '0;
        step("idle0", 4'b0000);

        // preload addresses 0..3 with random words, one channel each
        for (int k = 0; k < CH; k++)
            set_ch(k, k, {$urandom, $urandom, $urandom, $urandom});
        wr = '1;
        for (int k = 0; k < CH; k++) begin
            step("init_w", CH'(1 << k));
            wr[k] = 1'b0;
        end

        // continuous reads from all channels rotate from ch0
        rd = '1;
        for (int i = 0; i < 6; i++) step("rr", CH'(1 << (i % CH)));
        rd = '0;
        step("rr_drain", 4'b0000);

        // write via ch0, read back via ch2
        set_ch(0, 5, {16{8'h11}});
        wr = 4'b0001;
        step("w5", 4'b0001);
        wr = '0;
        set_ch(2, 5, '0);
        rd = 4'b0100;
        step("r5", 4'b0100);
        rd = '0;
        step("r5_vld", 4'b0000);
        step("r5_idle", 4'b0000);
        chk("r5_const", miso, {16{8'h11}});

        // read+write together behaves as a write
        set_ch(1, 7, 128'hAB);
        rd = 4'b0010; wr = 4'b0010;
        step("rw7", 4'b0010);
        rd = '0; wr = '0;
        step("rw7_novld", 4'b0000);
        rd = 4'b0010;
        step("r7", 4'b0010);
        rd = '0;
        step("r7_vld", 4'b0000);
        chk("r7_const", miso, 128'hAB);

        // clock-enable gap right after a read grant
        set_ch(3, 1, '0);
        rd = 4'b1000;
        step("gap_gnt", 4'b1000);
        en = 1'b0; rd = '1;
        for (int i = 0; i < 3; i++) step("gap", 4'b0000);
        en = 1'b1; rd = '0;
        step("gap_vld", 4'b0000);
        rd = '1;
        step("gap_ptr", 4'b0001);
        rd = '0;
        step("gap_ptr_vld", 4'b0000);

`ifdef RAM_SX_ARB_BYTE_EN
        set_ch(0, 9, '1);
        be[0 +: BW] = '1;
        wr = 4'b0001;
        step("be_full", 4'b0001);
        set_ch(0, 9, '0);
        be[0 +: BW] = 16'h0001;
        step("be_byte", 4'b0001);
        be[0 +: BW] = '0;
        step("be_none", 4'b0001);
        wr = '0; rd = 4'b0001;
        step("be_rd", 4'b0001);
        rd = '0;
        step("be_vld", 4'b0000);
        chk("be_const", miso, {{15{8'hFF}}, 8'h00});
`else
        set_ch(0, 9, '1);
        wr = 4'b0001;
        step("fw_a", 4'b0001);
        set_ch(0, 9, 128'h1234);
        step("fw_b", 4'b0001);
        wr = '0; rd = 4'b0001;
        step("fw_rd", 4'b0001);
        rd = '0;
        step("fw_vld", 4'b0000);
        chk("fw_const", miso, 128'h1234);
`endif

        // reset in the cycle after a read grant discards the read and rewinds the pointer
        set_ch(2, 5, '0);
        rd = 4'b0100;
        step("rst_gnt", 4'b0100);
        rst = 1'b1; rd = '1;
        step("rst_pend", 4'b0000);
        rst = 1'b0;
        step("rst_ptr", 4'b0001);
        rd = '0;
        step("rst_drain", 4'b0000);

        chk("sb_empty", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
